// File: rtl/cfa_pkg.sv
// Shared constants and payload types for the CFA interpolation blend stages.
package cfa_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WMAX  = 255;
  localparam int unsigned RND   = 128;
  // Product-sum width: 255*255 fits in 16 bits.
  localparam int unsigned XW    = 16;

  // Stage-1 payload: raw operands plus end-of-line tag.
  typedef struct packed {
    logic [PIX_W-1:0] weight;
    logic [PIX_W-1:0] pix_a;
    logic [PIX_W-1:0] pix_b;
    logic             last;
  } s1_t;

  // Stage-2 payload: weighted sum awaiting division by 255.
  typedef struct packed {
    logic [XW-1:0] x;
    logic          last;
  } s2_t;

endpackage

// File: rtl/blend_div255.sv
// Combinational round-half-up divide by 255 for x in 0..65025.
module blend_div255
  import cfa_pkg::*;
(
  input  logic [XW-1:0]    x,
  output logic [PIX_W-1:0] q
);

  logic [XW:0] y;
  logic [XW:0] s;

  // y + (y>>8) folds the 1/255 = 1/256 * (1 + 1/256 + ...) series; exact over the input range.
  assign y = (XW+1)'(x) + (XW+1)'(RND);
  assign s = y + (y >> 8);
  assign q = PIX_W'(s >> 8);

endmodule

// File: rtl/blend_mixer.sv
// Three-stage alpha blend of two candidate pixels with valid/ready flow control,
// end-of-line passthrough and a per-line accepted-beat counter.
module blend_mixer
  import cfa_pkg::*;
#(
  parameter int unsigned DW = PIX_W,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] weight,
  input  logic [DW-1:0] pix_a,
  input  logic [DW-1:0] pix_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] pix_out,
  output logic          out_last,
  output logic [CW-1:0] pix_cnt
);

  logic v1, v2, v3;
  logic r1, r2, r3;
  s1_t  s1;
  s2_t  s2;

  logic [PIX_W-1:0] inv_w;
  logic [XW-1:0]    x_c;
  logic [PIX_W-1:0] q_c;

  // Ready chain: each stage can take a beat when empty or when its successor moves.
  assign r3        = out_ready;
  assign r2        = !v3 || r3;
  assign r1        = !v2 || r2;
  assign in_ready  = !v1 || r1;
  assign out_valid = v3;

  // Weighted sum; 255 - weight cannot underflow for an 8-bit weight.
  assign inv_w = PIX_W'(WMAX) - s1.weight;
  assign x_c   = XW'(s1.pix_a) * XW'(inv_w) + XW'(s1.pix_b) * XW'(s1.weight);

  blend_div255 u_div (
    .x (s2.x),
    .q (q_c)
  );

  // Stage valid flags; reset discards every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (r1)       v2 <= v1;
      if (r2)       v3 <= v2;
    end
  end

  // Stage payloads; only real beats are captured so held data never changes under a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      pix_out  <= '0;
      out_last <= 1'b0;
    end else begin
      if (in_ready && in_valid) begin
        s1.weight <= PIX_W'(weight);
        s1.pix_a  <= PIX_W'(pix_a);
        s1.pix_b  <= PIX_W'(pix_b);
        s1.last   <= in_last;
      end
      if (r1 && v1) begin
        s2.x    <= x_c;
        s2.last <= s1.last;
      end
      if (r2 && v2) begin
        pix_out  <= DW'(q_c);
        out_last <= s2.last;
      end
    end
  end

  // Per-line output beat counter; the end-of-line transfer restarts it at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (out_valid && out_ready) begin
      pix_cnt <= out_last ? '0 : pix_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_blend_mixer.sv
// Directed and randomised checks of blend_mixer against a round(x/255) model.
module tb_blend_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  weight;
  logic [7:0]  pix_a;
  logic [7:0]  pix_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  pix_out;
  logic        out_last;
  logic [15:0] pix_cnt;

  logic [15:0] dx;
  logic [7:0]  dq;

  int checks   = 0;
  int failures = 0;

  localparam int NRND = 10000;

  blend_mixer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weight    (weight),
    .pix_a     (pix_a),
    .pix_b     (pix_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pix_out   (pix_out),
    .out_last  (out_last),
    .pix_cnt   (pix_cnt)
  );

  blend_div255 u_div_ref (
    .x (dx),
    .q (dq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Round-half-up of x/255 written as an integer floor.
  function automatic int div255_model(input int x);
    return (2 * x + 255) / 510;
  endfunction

  function automatic int blend_model(input int w, input int a, input int b);
    return div255_model(a * (255 - w) + b * w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: checks the 3-cycle latency and the blended value.
  task automatic send_one(input string tag, input int w, input int a, input int b, input int exp);
    in_valid  = 1'b1;
    weight    = 8'(w);
    pix_a     = 8'(a);
    pix_b     = 8'(b);
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, 32'(out_valid), 0);
    tick();
    @(negedge clk);
    chk({tag, "_lat2"}, 32'(out_valid), 0);
    tick();
    @(negedge clk);
    chk({tag, "_lat3_valid"}, 32'(out_valid), 1);
    chk({tag, "_pix"}, 32'(pix_out), 32'(exp));
    tick();
  endtask

  initial begin
    int sent;
    int got;
    bit acc;
    int q_pix[$];
    bit q_last[$];
    int mcnt;
    bit held;
    logic [7:0] hpix;
    logic hlast;
    int ep;
    bit el;
    int cyc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    weight    = '0;
    pix_a     = '0;
    pix_b     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    dx        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pix_out", 32'(pix_out), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_pix_cnt", 32'(pix_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    tick();

    // Endpoints, midpoint and equal operands
    send_one("w0", 0, 100, 200, 100);
    send_one("w255", 255, 100, 200, 200);
    send_one("w128", 128, 100, 200, 150);
    send_one("w77_eq", 77, 255, 255, 255);
    send_one("w1", 1, 0, 255, 1);
    send_one("w200_eq", 200, 37, 37, 37);

    // Stall: out_ready low for 6 cycles, 4 beats offered, last one ends the line
    sent = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sent < 4) begin
        in_valid = 1'b1;
        weight   = 8'd0;
        pix_a    = 8'(10 * (sent + 1));
        pix_b    = 8'd0;
        in_last  = (sent == 3);
      end
      @(negedge clk);
      if (i >= 3) begin
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_pix_hold", 32'(pix_out), 10);
      end
      acc = in_valid && in_ready;
      if (acc) sent++;
      tick();
      if (sent == 4) in_valid = 1'b0;
    end
    chk("stall_accepted", 32'(sent), 3);

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("stall_drain_pix", 32'(pix_out), 32'(10 * (got + 1)));
        chk("stall_drain_last", 32'(out_last), 32'(got == 3));
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) sent++;
      tick();
      if (sent == 4) in_valid = 1'b0;
    end
    chk("stall_drain_count", 32'(got), 4);
    @(negedge clk);
    chk("stall_no_dup", 32'(out_valid), 0);
    chk("stall_cnt_line_end", 32'(pix_cnt), 0);
    tick();

    // Line of 5 beats at full rate, end-of-line on the fifth
    sent = 0;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (sent < 5) begin
        in_valid = 1'b1;
        weight   = 8'd0;
        pix_a    = 8'(sent + 1);
        pix_b    = 8'd99;
        in_last  = (sent == 4);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        chk("line_pix", 32'(pix_out), 32'(got + 1));
        chk("line_last", 32'(out_last), 32'(got == 4));
        chk("line_cnt", 32'(pix_cnt), 32'(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("line_count", 32'(got), 5);
    @(negedge clk);
    chk("line_cnt_after", 32'(pix_cnt), 0);
    tick();

    // Mid-flight reset with 3 beats in the pipe
    send_one("pre_rst", 0, 7, 0, 7);
    @(negedge clk);
    chk("pre_rst_cnt", 32'(pix_cnt), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      weight   = 8'd255;
      pix_a    = 8'd0;
      pix_b    = 8'(50 + i);
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("post_rst_cnt", 32'(pix_cnt), 0);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("post_rst_no_stale", 32'(out_valid), 0);
    end
    tick();

    // Random valid/ready traffic against a scoreboard
    sent = 0;
    got = 0;
    mcnt = 0;
    held = 1'b0;
    hpix = '0;
    hlast = 1'b0;
    cyc = 0;
    in_valid = 1'b0;
    while ((sent < NRND || got < NRND) && cyc < 60000) begin
      if (!in_valid && sent < NRND && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        weight   = 8'($urandom_range(0, 255));
        pix_a    = 8'($urandom_range(0, 255));
        pix_b    = 8'($urandom_range(0, 255));
        in_last  = ($urandom_range(0, 7) == 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (held) begin
        chk("rnd_hold_valid", 32'(out_valid), 1);
        chk("rnd_hold_pix", 32'(pix_out), 32'(hpix));
        chk("rnd_hold_last", 32'(out_last), 32'(hlast));
      end
      if (out_valid && out_ready) begin
        if (q_pix.size() > 0) begin
          ep = q_pix.pop_front();
          el = q_last.pop_front();
          chk("rnd_pix", 32'(pix_out), 32'(ep));
          chk("rnd_last", 32'(out_last), 32'(el));
          chk("rnd_cnt", 32'(pix_cnt), 32'(mcnt));
          mcnt = el ? 0 : ((mcnt + 1) & 16'hFFFF);
        end else begin
          chk("rnd_spurious", 32'(out_valid), 0);
        end
        got++;
      end
      held  = out_valid && !out_ready;
      hpix  = pix_out;
      hlast = out_last;
      acc = in_valid && in_ready;
      if (acc) begin
        q_pix.push_back(blend_model(int'(weight), int'(pix_a), int'(pix_b)));
        q_last.push_back(in_last);
        sent++;
      end
      tick();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_sent", 32'(sent), NRND);
    chk("rnd_received", 32'(got), NRND);
    chk("rnd_queue_empty", 32'(q_pix.size()), 0);

    // Exhaustive divider sweep over every reachable weighted sum
    for (int x = 0; x <= 65025; x++) begin
      dx = 16'(x);
      #1;
      chk("div255", 32'(dq), 32'(div255_model(x)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
